// File: rtl/ao_obi_buffer_pkg.sv
// Purpose: shared OBI types, defaults and a counter-width helper for the AO slave buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ao_obi_buffer_pkg;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;
    localparam int          TIMEOUT_DEFAULT   = 1024;

    // OBI request as seen on the bus (A channel).
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    // OBI response (grant plus R channel).
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Request FIFO payload: everything but the req strobe itself.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_entry_t;

    // Width needed to count 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ao_obi_sync_fifo.sv
// Purpose: generic synchronous FIFO; ports push/push_data, pop/pop_data, full, empty, clk, rst.
// Latency: one cycle from push to data visible at the head (no bypass).
// Backpressure: push ignored while full, pop ignored while empty; callers gate on full/empty.
module ao_obi_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ao_obi_slave_buffer.sv
// Purpose: OBI slave buffer in front of the AO peripheral port; req/resp FIFOs, outstanding cap, hang timeout.
// Latency: producer gnt -> consumer req +1 cycle; consumer rvalid -> producer rvalid +1 cycle.
// Backpressure: producer gnt drops when the request FIFO is full or MAX_OUT are outstanding; no rvalid backpressure.
// Ports: clk_i/rst_i (sync, active-high), producer_req_i/producer_resp_o (system bus side),
//        consumer_req_o/consumer_resp_i (AO side), clear_timeout_i, timeout_o (sticky), outstanding_o.
module ao_obi_slave_buffer
    import ao_obi_buffer_pkg::*;
#(
    parameter int          REQ_DEPTH      = 2,
    parameter int          MAX_OUT        = 4,
    parameter int          TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  obi_req_t                  producer_req_i,
    output obi_resp_t                 producer_resp_o,
    output obi_req_t                  consumer_req_o,
    input  obi_resp_t                 consumer_resp_i,
    input  logic                      clear_timeout_i,
    output logic                      timeout_o,
    output logic [cnt_w(MAX_OUT)-1:0] outstanding_o
);

    localparam int OW = cnt_w(MAX_OUT);
    // Keep the timer at least one bit wide even when the timeout is disabled.
    localparam int TW = cnt_w((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1);

    req_entry_t    req_in;
    req_entry_t    req_head;
    logic          req_full;
    logic          req_empty;
    logic          prod_gnt;
    logic          cons_gnt;
    logic          cons_rvalid;
    logic          rsp_take;
    logic          rsp_drop;
    logic          tmo_fire;
    logic          resp_push;
    logic [31:0]   resp_push_data;
    logic [31:0]   resp_head;
    logic          resp_full;
    logic          resp_empty;
    logic          resp_vld;
    logic [OW-1:0] out_cnt;
    logic [OW-1:0] cons_cnt;
    logic [OW-1:0] drop_cnt;
    logic [TW-1:0] tmo_cnt;

    // ---------------- producer side ----------------
    assign prod_gnt = producer_req_i.req && !rst_i && !req_full && (out_cnt < OW'(MAX_OUT));

    always_comb begin
        req_in       = '0;
        req_in.addr  = producer_req_i.addr;
        req_in.we    = producer_req_i.we;
        req_in.be    = producer_req_i.be;
        req_in.wdata = producer_req_i.wdata;
    end

    ao_obi_sync_fifo #(
        .WIDTH ($bits(req_entry_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (prod_gnt),
        .push_data (req_in),
        .pop       (cons_gnt),
        .pop_data  (req_head),
        .full      (req_full),
        .empty     (req_empty)
    );

    // ---------------- consumer side ----------------
    always_comb begin
        consumer_req_o       = '0;
        consumer_req_o.req   = !req_empty;
        consumer_req_o.we    = req_head.we;
        consumer_req_o.be    = req_head.be;
        consumer_req_o.addr  = req_head.addr;
        consumer_req_o.wdata = req_head.wdata;
    end

    assign cons_gnt    = !req_empty && consumer_resp_i.gnt;
    assign cons_rvalid = consumer_resp_i.rvalid;

    // A response while drops are pending is the late answer to a timed-out
    // transaction. A response with nothing in flight (e.g. after a reset) is ignored.
    assign rsp_drop = cons_rvalid && (drop_cnt != '0);
    assign rsp_take = cons_rvalid && (drop_cnt == '0) && (cons_cnt != '0);

    // A real rvalid in the timeout cycle wins, so at most one push per cycle.
    assign tmo_fire = (TIMEOUT_CYCLES != 0) && (cons_cnt != '0) && !cons_rvalid &&
                      (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign resp_push      = rsp_take || tmo_fire;
    assign resp_push_data = tmo_fire ? ERR_RDATA : consumer_resp_i.rdata;

    ao_obi_sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUT)
    ) u_resp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (resp_push),
        .push_data (resp_push_data),
        .pop       (resp_vld),
        .pop_data  (resp_head),
        .full      (resp_full),
        .empty     (resp_empty)
    );

    assign resp_vld = !resp_empty;

    always_comb begin
        producer_resp_o        = '0;
        producer_resp_o.gnt    = prod_gnt;
        producer_resp_o.rvalid = resp_vld;
        producer_resp_o.rdata  = resp_head;
    end

    assign outstanding_o = out_cnt;

    // ---------------- counters and timeout ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt   <= '0;
            cons_cnt  <= '0;
            drop_cnt  <= '0;
            tmo_cnt   <= '0;
            timeout_o <= 1'b0;
        end else begin
            out_cnt  <= out_cnt + OW'(prod_gnt) - OW'(resp_vld);
            cons_cnt <= cons_cnt + OW'(cons_gnt) - OW'(resp_push);
            drop_cnt <= drop_cnt + OW'(tmo_fire) - OW'(rsp_drop);
            if ((cons_cnt == '0) || cons_rvalid || tmo_fire) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            // A new timeout beats a simultaneous clear.
            if (tmo_fire) begin
                timeout_o <= 1'b1;
            end else if (clear_timeout_i) begin
                timeout_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(resp_push && resp_full));
            assert (drop_cnt <= OW'(MAX_OUT));
        end
    end

endmodule

// File: tb/tb_ao_obi_slave_buffer.sv
// Purpose: directed, scoreboard-checked bench for ao_obi_slave_buffer (TIMEOUT_CYCLES=16).
// Latency: inputs driven 1 time unit after posedge, outputs sampled 4 units after posedge.
// Backpressure: consumer gnt/rvalid driven directly by the directed steps.
module tb_ao_obi_slave_buffer;
    import ao_obi_buffer_pkg::*;

    localparam logic [31:0] ERR = 32'hBADCAB1E;

    logic       clk_i = 1'b0;
    logic       rst_i;
    obi_req_t   preq;
    obi_resp_t  presp;
    obi_req_t   creq;
    obi_resp_t  cresp;
    logic       clr;
    logic       tmo;
    logic [2:0] outst;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb [$];

    always #5 clk_i = ~clk_i;

    ao_obi_slave_buffer #(
        .REQ_DEPTH      (2),
        .MAX_OUT        (4),
        .TIMEOUT_CYCLES (16),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .producer_req_i  (preq),
        .producer_resp_o (presp),
        .consumer_req_o  (creq),
        .consumer_resp_i (cresp),
        .clear_timeout_i (clr),
        .timeout_o       (tmo),
        .outstanding_o   (outst)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic drive_req(input logic r, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata);
        preq.req   = r;
        preq.we    = we;
        preq.be    = 4'hF;
        preq.addr  = addr;
        preq.wdata = wdata;
    endtask

    // Scoreboard: every producer rvalid must match the oldest expected rdata.
    always @(negedge clk_i) begin
        if (!rst_i && presp.rvalid) begin
            if (sb.size() == 0) chk("rvalid_unexpected", presp.rvalid, 1'b0);
            else chk("rdata", presp.rdata, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        preq  = '0;
        cresp = '0;
        clr   = 1'b0;
        rst_i = 1'b1;
        cyc();
        cyc();
        smp();
        chk("rst_gnt", presp.gnt, 0);
        chk("rst_creq", creq.req, 0);
        chk("rst_prv", presp.rvalid, 0);
        chk("rst_outst", outst, 0);
        chk("rst_tmo", tmo, 0);
        rst_i = 1'b0;

        // ---- T1 single read ----
        cresp.gnt = 1'b1;
        cyc(); drive_req(1, 0, 32'h2000_0000, 0);           // A
        smp(); chk("t1_pgnt", presp.gnt, 1); chk("t1_creq_early", creq.req, 0);
        cyc(); drive_req(0, 0, 0, 0);                         // A+1
        smp(); chk("t1_creq", creq.req, 1); chk("t1_caddr", creq.addr, 32'h2000_0000);
        chk("t1_outst", outst, 1);
        cyc(); cyc();                                         // A+3
        cresp.rvalid = 1'b1; cresp.rdata = 32'h1234_5678; sb.push_back(32'h1234_5678);
        smp(); chk("t1_prv_early", presp.rvalid, 0);
        cyc(); cresp.rvalid = 1'b0;                           // A+4
        smp(); chk("t1_prv", presp.rvalid, 1);
        cyc(); smp(); chk("t1_outst_done", outst, 0);

        // ---- T2 backpressure ----
        cresp.gnt = 1'b0;
        cyc(); drive_req(1, 0, 32'h3000_0000, 0);             // B
        smp(); chk("t2_gnt0", presp.gnt, 1);
        cyc(); drive_req(1, 0, 32'h3000_0004, 0);             // B+1
        smp(); chk("t2_gnt1", presp.gnt, 1); chk("t2_caddr_b1", creq.addr, 32'h3000_0000);
        cyc(); drive_req(1, 0, 32'h3000_0008, 0);             // B+2
        smp(); chk("t2_gnt2_full", presp.gnt, 0); chk("t2_caddr_b2", creq.addr, 32'h3000_0000);
        cyc();                                                // B+3
        smp(); chk("t2_gnt2_held", presp.gnt, 0); chk("t2_caddr_b3", creq.addr, 32'h3000_0000);
        chk("t2_creq_b3", creq.req, 1);
        cyc(); drive_req(0, 0, 0, 0); cresp.gnt = 1'b1;       // B+4
        smp(); chk("t2_caddr_b4", creq.addr, 32'h3000_0000);
        cyc();                                                // B+5
        smp(); chk("t2_caddr_b5", creq.addr, 32'h3000_0004);
        cyc(); cresp.rvalid = 1'b1; cresp.rdata = 32'hD000_0000; sb.push_back(32'hD000_0000);
        cyc(); cresp.rdata = 32'hD000_0001; sb.push_back(32'hD000_0001);
        cyc(); cresp.rvalid = 1'b0;
        cyc(); cyc();
        smp(); chk("t2_outst_done", outst, 0);

        // ---- T3 outstanding limit ----
        for (int i = 0; i < 4; i++) begin
            cyc(); drive_req(1, 0, 32'h4000_0000 + 32'(4 * i), 0);
            smp(); chk("t3_gnt", presp.gnt, 1);
        end
        cyc(); drive_req(1, 0, 32'h4000_0010, 0);             // C+4
        smp(); chk("t3_gnt5_blocked", presp.gnt, 0); chk("t3_outst4", outst, 4);
        cyc(); cresp.rvalid = 1'b1; cresp.rdata = 32'hE000_0000; sb.push_back(32'hE000_0000);
        smp(); chk("t3_gnt5_c5", presp.gnt, 0);
        cyc(); cresp.rvalid = 1'b0;                           // C+6
        smp(); chk("t3_gnt5_c6", presp.gnt, 0);
        cyc();                                                // C+7
        smp(); chk("t3_gnt5_after_rsp", presp.gnt, 1);
        cyc(); drive_req(0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) cyc();
            cresp.rvalid = 1'b1;
            cresp.rdata  = 32'hE000_0000 + 32'(i);
            sb.push_back(32'hE000_0000 + 32'(i));
        end
        cyc(); cresp.rvalid = 1'b0;
        cyc();
        smp(); chk("t3_outst_done", outst, 0);

        // ---- T4 timeout ----
        // Consumer gnt at D+1; timer runs from D+2, reaches 15 at D+17, error pushed
        // that cycle, producer rvalid at D+18.
        cyc(); drive_req(1, 0, 32'h5000_0000, 0); sb.push_back(ERR);   // D
        cyc(); drive_req(0, 0, 0, 0);                                  // D+1
        repeat (15) cyc();                                             // D+16
        smp(); chk("t4_tmo_d16", tmo, 0); chk("t4_prv_d16", presp.rvalid, 0);
        cyc();                                                         // D+17
        smp(); chk("t4_prv_d17", presp.rvalid, 0); chk("t4_tmo_d17", tmo, 0);
        cyc();                                                         // D+18
        smp(); chk("t4_prv_err", presp.rvalid, 1); chk("t4_tmo_set", tmo, 1);
        cyc(); cyc(); cresp.rvalid = 1'b1; cresp.rdata = 32'hDEAD_0001; // late answer
        cyc(); cresp.rvalid = 1'b0;
        smp(); chk("t4_late_dropped", presp.rvalid, 0); chk("t4_tmo_sticky", tmo, 1);
        cyc(); drive_req(1, 0, 32'h5000_0004, 0);
        cyc(); drive_req(0, 0, 0, 0);
        cyc(); cyc(); cresp.rvalid = 1'b1; cresp.rdata = 32'h5555_AAAA; sb.push_back(32'h5555_AAAA);
        cyc(); cresp.rvalid = 1'b0;
        cyc(); clr = 1'b1;
        smp(); chk("t4_tmo_before_clr", tmo, 1);
        cyc(); clr = 1'b0;
        smp(); chk("t4_tmo_cleared", tmo, 0);

        // ---- T5 race: real rvalid on the timeout cycle ----
        cyc(); drive_req(1, 0, 32'h6000_0000, 0);             // F
        cyc(); drive_req(0, 0, 0, 0);                         // F+1
        repeat (16) cyc();                                    // F+17
        cresp.rvalid = 1'b1; cresp.rdata = 32'hCAFE_0005; sb.push_back(32'hCAFE_0005);
        cyc(); cresp.rvalid = 1'b0;                           // F+18
        smp(); chk("t5_prv", presp.rvalid, 1); chk("t5_tmo", tmo, 0);
        cyc();
        smp(); chk("t5_drop_cnt", dut.drop_cnt, 0); chk("t5_tmo_after", tmo, 0);
        chk("t5_outst", outst, 0);
        // A following write must get its own response (nothing pending to drop).
        cyc(); drive_req(1, 1, 32'h6000_0010, 32'hA5A5_0F0F);
        smp(); chk("t5_wr_gnt", presp.gnt, 1);
        cyc(); drive_req(0, 0, 0, 0);
        smp(); chk("t5_wr_we", creq.we, 1); chk("t5_wr_wdata", creq.wdata, 32'hA5A5_0F0F);
        chk("t5_wr_be", creq.be, 4'hF);
        cyc(); cyc(); cresp.rvalid = 1'b1; cresp.rdata = 32'h0000_0000; sb.push_back(32'h0000_0000);
        cyc(); cresp.rvalid = 1'b0;
        cyc(); cyc();

        // ---- T6 reset mid-operation ----
        cresp.gnt = 1'b1;
        cyc(); drive_req(1, 0, 32'h7000_0000, 0);             // H
        cyc(); drive_req(1, 0, 32'h7000_0004, 0);             // H+1
        cyc(); cresp.gnt = 1'b0; drive_req(1, 0, 32'h7000_0008, 0); // H+2
        smp(); chk("t6_gnt_p2", presp.gnt, 1);
        cyc(); drive_req(0, 0, 0, 0); rst_i = 1'b1;            // H+3
        smp(); chk("t6_pre_outst", outst, 3); chk("t6_pre_creq", creq.req, 1);
        cyc(); rst_i = 1'b0;                                  // H+4
        smp(); chk("t6_gnt", presp.gnt, 0); chk("t6_creq", creq.req, 0);
        chk("t6_prv", presp.rvalid, 0); chk("t6_outst", outst, 0); chk("t6_tmo", tmo, 0);
        cyc(); cresp.rvalid = 1'b1; cresp.rdata = 32'h7777_7777;  // stale, untracked
        cyc(); cresp.rvalid = 1'b0;
        smp(); chk("t6_stale_ignored", presp.rvalid, 0);
        cresp.gnt = 1'b1;
        cyc(); drive_req(1, 0, 32'h7000_0100, 0);
        smp(); chk("t6_post_gnt", presp.gnt, 1);
        cyc(); drive_req(0, 0, 0, 0);
        cyc(); cresp.rvalid = 1'b1; cresp.rdata = 32'h1357_9BDF; sb.push_back(32'h1357_9BDF);
        cyc(); cresp.rvalid = 1'b0;
        cyc(); cyc();
        smp(); chk("sb_drained", sb.size(), 0); chk("final_outst", outst, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
